num_display_scanner: RTL
========================

Name: num_display_scanner

Overview:
- RTL successor to the bench-only segment printer. Formats a `calc_pkg::num_t` into a frame of seven-segment bytes, with sign, decimal point and fixed or scientific mode.
- Drives a time-multiplexed display: one digit at a time, with a programmable scan rate.
- Sits between the calculator core result register and the board display pins.
- Parametrised in digit count and scan divider.

Parameters:
- NumDigits, default calc_pkg::NumDigits (8): significand digits. Display has D = NumDigits+1 positions; position D-1 is the sign/error position.
- ScanDiv, default 1024: clock cycles per scan position; legal range ≥1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- num_valid_i  in  1  number offered for formatting.
- num_ready_o  out  1  formatter idle; load accepted on valid&ready edge.
- num_i  in  calc_pkg::num_t  sign, error, BCD significand[NumDigits-1:0], exponent.
- sci_i  in  1  1 = scientific mode, 0 = fixed mode; sampled with the load.
- segments_o  out  D×8  committed frame; position p byte at [p].
- fmt_done_o  out  1  one-cycle pulse when a new frame commits.
- scan_an_o  out  D  one-hot active-high digit enable.
- scan_seg_o  out  8  segment byte for the enabled digit.

Behaviour:
- Segment bit map, active-high:
  - 6 top, 5 upper-right, 4 lower-right, 3 bottom, 2 lower-left, 1 upper-left, 0 middle, 7 dp.
  - Digits 0-9: 7E 30 6D 79 33 5B 5F 70 7F 7B.
  - minus = 01, 'E' = 4F, blank = 00.
- Reset (async, rst_ni low):
  - FSM returns to IDLE and any in-progress format is aborted.
  - num_ready_o=1, segments_o=0, fmt_done_o=0, scan_an_o=1 (bit 0), scan_seg_o=0, prescaler=0.
- FSM states:
  - IDLE: num_ready_o=1. On valid&ready, latch num_i and sci_i, set k=0, go to FMT. Position counter k counts 0..D-1.
  - FMT: num_ready_o=0. One position per cycle from position 0 (rightmost) up to D-1, written into a shadow buffer. After k=D-1, go to COMMIT. num_valid_i is ignored.
  - COMMIT: shadow buffer copied to segments_o. fmt_done_o=1 for this one cycle. Go to IDLE.
- Latency: with acceptance at edge T, segments_o and the fmt_done_o pulse appear after edge T+D+1, and num_ready_o returns high after that same edge.
- Error frame: used when error=1 or any significand digit is above 9. Position D-1 = 4F; all other positions = 00.
- Sign position D-1 (non-error): 01 if sign=1, else 00.
- Fixed mode (sci_i=0, exponent < NumDigits):
  - Digit d_i (i=0 is the MSD, significand[NumDigits-1]) goes to position NumDigits-1-i.
  - dp is set on position NumDigits-1-exponent.
- Scientific mode:
  - Used when sci_i=1, or in fixed mode when exponent ≥ NumDigits (automatic fallback).
  - d_0 plus dp goes to position NumDigits-1.
  - d_1..d_{NumDigits-2} go to positions NumDigits-2..1; d_{NumDigits-1} is truncated, not rounded.
  - Position 0 = exponent digit.
  - If exponent > 9, the error frame is used instead.
- Scanner runs continuously, independent of the FSM:
  - Prescaler counts 0..ScanDiv-1.
  - On wrap, the scan index advances, wrapping from D-1 to 0.
  - scan_an_o and scan_seg_o are registered; scan_seg_o = segments_o[index] at the time of update.
  - A commit mid-scan takes effect at the next index update; no tearing within a digit.
- ScanDiv=1: index advances every cycle.

Optional Feature:
- Macro: DISPLAY_TRAILING_BLANK_EN.
- When defined, in both modes:
  - FMT carries a "still trailing" flag while scanning from position 0 upward (sci mode starts at position 1; the exponent digit is never blanked).
  - Zero digits strictly right of the dp position are blanked (00) until the first non-zero digit.
  - The dp digit itself is never blanked.
- When undefined, all zeros are displayed. Latency is identical either way.

Test Plan:
- Fixed value, -1.2345678×10^2, sci_i=0 (NumDigits=8):
  - Frame: pos8=01, pos7=30, pos6=6D, pos5=F9, pos4=33, pos3=5B, pos2=5F, pos1=70, pos0=7F.
  - fmt_done_o pulses exactly 10 cycles after acceptance.
- Error display:
  - error=1 → pos8=4F, others 00.
  - Significand digit of 0xC with error=0 → same error frame.
- Scientific mode, +9.0000000×10^7, sci_i=1:
  - Without macro: pos7=FB, pos6..1=7E, pos0=70.
  - With DISPLAY_TRAILING_BLANK_EN: pos6..1=00.
- Fixed-mode fallback and zero:
  - 5.0000000×10^8, sci_i=0 → falls back to sci, pos0=7F.
  - Zero, fixed mode, with macro → pos7=FE, pos6..0=00.
- Scanner, ScanDiv=4: scan_an_o steps 001→002→…→100 every 4 cycles and returns to 001 after 36 cycles. scan_seg_o matches segments_o of the enabled digit.
- Handshake and reset:
  - num_valid_i held high during FMT → num_ready_o=0, no second load; second value accepted after COMMIT.
  - rst_ni low mid-FMT → segments_o=0, num_ready_o=1 immediately, and no fmt_done_o pulse.

Source files
------------

// File: rtl/num_display_scanner.sv
// ============================================================================
// Module   : num_display_scanner (plus calc_pkg, the shared number type)
// Purpose  : Formats a calc_pkg::num_t into a frame of seven-segment bytes
//            (sign, decimal point, fixed or scientific layout) and drives a
//            time-multiplexed display one digit at a time.
//            The display has D = NUM_DIGITS+1 positions. Position 0 is the
//            rightmost, and position D-1 holds the sign or the error 'E'.
// Ports    : clk_i        clock
//            rst_ni       asynchronous active-low reset
//            num_valid_i  number offered for formatting
//            num_ready_o  formatter idle (load on valid & ready)
//            num_i        sign, error, BCD significand, exponent
//            sci_i        1 = scientific, 0 = fixed (sampled with the load)
//            segments_o   committed frame, byte of position p at [p]
//            fmt_done_o   one-cycle pulse when a new frame commits
//            scan_an_o    one-hot active-high digit enable
//            scan_seg_o   segment byte for the enabled digit
// Params   : NUM_DIGITS   significand digits (must equal calc_pkg::NumDigits)
//            SCAN_DIV     clock cycles per scan position (>= 1)
// Options  : DISPLAY_TRAILING_BLANK_EN  blank zeros right of the dp up to
//            the first non-zero digit
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package calc_pkg;
    localparam int NumDigits = 8;
    localparam int ExpWidth  = 8;

    // significand[NumDigits-1] is the most significant digit
    typedef struct packed {
        logic                      sign;
        logic                      error;
        logic [NumDigits-1:0][3:0] significand;
        logic [ExpWidth-1:0]       exponent;
    } num_t;
endpackage

module num_display_scanner #(
    parameter int NUM_DIGITS = calc_pkg::NumDigits,
    parameter int SCAN_DIV   = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      num_valid_i,
    output logic                      num_ready_o,
    input  calc_pkg::num_t            num_i,
    input  logic                      sci_i,
    output logic [NUM_DIGITS:0][7:0]  segments_o,
    output logic                      fmt_done_o,
    output logic [NUM_DIGITS:0]       scan_an_o,
    output logic [7:0]                scan_seg_o
);

    localparam int c_D  = NUM_DIGITS + 1;
    localparam int c_KW = $clog2(c_D);
    localparam int c_PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_EW = calc_pkg::ExpWidth;

    localparam logic [c_KW-1:0] c_LAST_POS = c_KW'(c_D - 1);
    localparam logic [c_KW-1:0] c_MSD_POS  = c_KW'(NUM_DIGITS - 1);
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(SCAN_DIV - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_FMT    = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

`ifdef DISPLAY_TRAILING_BLANK_EN
    localparam logic c_TRAIL_EN = 1'b1;
`else
    localparam logic c_TRAIL_EN = 1'b0;
`endif

    function automatic logic [7:0] f_digit_seg(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'h7E;
            4'd1:    seg = 8'h30;
            4'd2:    seg = 8'h6D;
            4'd3:    seg = 8'h79;
            4'd4:    seg = 8'h33;
            4'd5:    seg = 8'h5B;
            4'd6:    seg = 8'h5F;
            4'd7:    seg = 8'h70;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h7B;
            default: seg = 8'h00;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic                   w_ready;
    logic                   w_accept;

    logic [c_KW-1:0]        r_k;
    calc_pkg::num_t         r_num;
    logic                   r_sci;
    logic                   r_trail;
    logic [c_D-1:0][7:0]    r_shadow;
    logic [c_D-1:0][7:0]    r_segments;
    logic                   r_done;

    logic [c_PW-1:0]        r_presc;
    logic [c_KW-1:0]        r_idx;
    logic [c_KW-1:0]        w_idx_nxt;
    logic [c_D-1:0]         r_an;
    logic [7:0]             r_seg;

    // ------------------------------------------------------------------
    // Frame decode from the latched number
    // ------------------------------------------------------------------
    logic                   w_bad_digit;
    logic                   w_use_sci;
    logic                   w_err;
    logic [c_KW-1:0]        w_dp_pos;
    logic [c_D-1:0][7:0]    w_raw;
    logic [c_D-1:0]         w_elig;
    logic                   w_cur_skip;
    logic                   w_blank;
    logic [7:0]             w_byte;

    always_comb begin
        w_bad_digit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_num.significand[i] > 4'd9) begin
                w_bad_digit = 1'b1;
            end
        end
    end

    // Fixed layout cannot show an exponent beyond the digit field, so it
    // falls back to scientific; scientific only has one exponent digit.
    assign w_use_sci = r_sci | (r_num.exponent >= c_EW'(NUM_DIGITS));
    assign w_err     = r_num.error | w_bad_digit
                     | (w_use_sci & (r_num.exponent > c_EW'(9)));
    assign w_dp_pos  = w_use_sci ? c_MSD_POS
                                 : (c_MSD_POS - c_KW'(r_num.exponent));

    // In both layouts digit position p shows significand[p]; scientific
    // mode replaces position 0 with the exponent digit.
    for (genvar p = 0; p < c_D; p++) begin : g_pos
        if (p == c_D - 1) begin : g_sign
            assign w_raw[p]  = w_err ? 8'h4F : (r_num.sign ? 8'h01 : 8'h00);
            assign w_elig[p] = 1'b0;
        end else begin : g_digit
            logic       w_is_exp;
            logic [3:0] w_digit;
            assign w_is_exp  = w_use_sci & (p == 0);
            assign w_digit   = w_is_exp ? r_num.exponent[3:0]
                                        : r_num.significand[p];
            assign w_raw[p]  = w_err ? 8'h00
                             : (f_digit_seg(w_digit)
                                | ((w_dp_pos == c_KW'(p)) ? 8'h80 : 8'h00));
            // A zero strictly right of the dp may be blanked.
            assign w_elig[p] = ~w_err & ~w_is_exp
                             & (c_KW'(p) < w_dp_pos) & (w_digit == 4'd0);
        end
    end

    // The exponent digit never breaks the trailing run; it is just skipped.
    assign w_cur_skip = w_use_sci & (r_k == '0);
    assign w_blank    = c_TRAIL_EN & r_trail & w_elig[r_k];
    assign w_byte     = w_blank ? 8'h00 : w_raw[r_k];

    // ------------------------------------------------------------------
    // Formatter FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_ready = 1'b1;
                if (num_valid_i) begin
                    w_state_nxt = c_ST_FMT;
                end
            end
            c_ST_FMT: begin
                if (r_k == c_LAST_POS) begin
                    w_state_nxt = c_ST_COMMIT;
                end
            end
            c_ST_COMMIT: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign w_accept = num_valid_i & w_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_k        <= '0;
            r_num      <= '0;
            r_sci      <= 1'b0;
            r_trail    <= 1'b0;
            r_shadow   <= '0;
            r_segments <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_num   <= num_i;
                        r_sci   <= sci_i;
                        r_k     <= '0;
                        r_trail <= 1'b1;
                    end
                end
                c_ST_FMT: begin
                    r_shadow[r_k] <= w_byte;
                    r_k           <= r_k + c_KW'(1);
                    r_trail       <= r_trail & (w_blank | w_cur_skip);
                end
                c_ST_COMMIT: begin
                    r_segments <= r_shadow;
                    r_done     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display scanner: free-running, samples the committed frame only when
    // the index moves, so a commit never changes a digit mid-slot.
    // ------------------------------------------------------------------
    assign w_idx_nxt = (r_idx == c_LAST_POS) ? '0 : (r_idx + c_KW'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_an    <= c_D'(1);
            r_seg   <= 8'h00;
        end else if (r_presc == c_PRE_LAST) begin
            r_presc <= '0;
            r_idx   <= w_idx_nxt;
            r_an    <= c_D'(1) << w_idx_nxt;
            r_seg   <= r_segments[w_idx_nxt];
        end else begin
            r_presc <= r_presc + c_PW'(1);
        end
    end

    assign num_ready_o = w_ready;
    assign segments_o  = r_segments;
    assign fmt_done_o  = r_done;
    assign scan_an_o   = r_an;
    assign scan_seg_o  = r_seg;

endmodule

`default_nettype wire
